// File: rtl/ball_plate_pkg.sv
// rtl/ball_plate_pkg.sv - shared command width, defaults and scheduler state encoding
package ball_plate_pkg;

   localparam int CMD_W = 12;

   localparam logic [CMD_W-1:0] CMD_CENTER_DEF = 12'd2048;
   localparam logic [CMD_W-1:0] CMD_MIN_DEF    = 12'd1024;
   localparam logic [CMD_W-1:0] CMD_MAX_DEF    = 12'd3072;
   localparam logic [CMD_W-1:0] MAX_STEP_DEF   = 12'd256;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LATCH   = 3'd1,
      S_ARM     = 3'd2,
      S_WAIT    = 3'd3,
      S_PUBLISH = 3'd4,
      S_FAULT   = 3'd5
   } sched_state_t;

   function automatic logic [CMD_W-1:0] clamp_cmd(input logic [CMD_W-1:0] v,
                                                  input logic [CMD_W-1:0] lo,
                                                  input logic [CMD_W-1:0] hi);
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

endpackage

// File: rtl/axis_control_scheduler_if.sv
// rtl/axis_control_scheduler_if.sv - operand/strobe/result bus between scheduler and the two axis controllers
interface axis_control_scheduler_if;
   import ball_plate_pkg::*;

   logic [CMD_W-1:0] ctl_x_desired;
   logic [CMD_W-1:0] ctl_x_actual;
   logic [CMD_W-1:0] ctl_y_desired;
   logic [CMD_W-1:0] ctl_y_actual;
   logic             ctl_start;
   logic [CMD_W-1:0] ctl_x_cmd;
   logic             ctl_x_val;
   logic [CMD_W-1:0] ctl_y_cmd;
   logic             ctl_y_val;

   modport master (
      output ctl_x_desired, ctl_x_actual, ctl_y_desired, ctl_y_actual, ctl_start,
      input  ctl_x_cmd, ctl_x_val, ctl_y_cmd, ctl_y_val
   );

   modport slave (
      input  ctl_x_desired, ctl_x_actual, ctl_y_desired, ctl_y_actual, ctl_start,
      output ctl_x_cmd, ctl_x_val, ctl_y_cmd, ctl_y_val
   );

endinterface

// File: rtl/cmd_shaper.sv
// rtl/cmd_shaper.sv - combinational clamp and slew limit of one axis command
module cmd_shaper
   import ball_plate_pkg::*;
#(
   parameter logic [CMD_W-1:0] CMD_MIN  = CMD_MIN_DEF,
   parameter logic [CMD_W-1:0] CMD_MAX  = CMD_MAX_DEF,
   parameter logic [CMD_W-1:0] MAX_STEP = MAX_STEP_DEF
) (
   input  logic [CMD_W-1:0] cmd,
   input  logic [CMD_W-1:0] prev,
   output logic [CMD_W-1:0] shaped
);

   logic [CMD_W-1:0]        c;
   logic signed [CMD_W:0]   d;
   logic signed [CMD_W:0]   step;

   // One extra bit keeps the difference of two unsigned commands exact and signed.
   always_comb begin
      c    = clamp_cmd(cmd, CMD_MIN, CMD_MAX);
      d    = signed'({1'b0, c}) - signed'({1'b0, prev});
      step = signed'({1'b0, MAX_STEP});
      if (d > step)
         shaped = prev + MAX_STEP;
      else if (d < -step)
         shaped = prev - MAX_STEP;
      else
         shaped = c;
   end

endmodule

// File: rtl/axis_control_scheduler.sv
// rtl/axis_control_scheduler.sv - per-tick sequencing of X/Y controllers, watchdog and coherent command publish
module axis_control_scheduler
   import ball_plate_pkg::*;
#(
   parameter logic [CMD_W-1:0] CMD_CENTER  = CMD_CENTER_DEF,
   parameter logic [CMD_W-1:0] CMD_MIN     = CMD_MIN_DEF,
   parameter logic [CMD_W-1:0] CMD_MAX     = CMD_MAX_DEF,
   parameter logic [CMD_W-1:0] MAX_STEP    = MAX_STEP_DEF,
   parameter int               TIMEOUT_CYC = 32,
   parameter int               OVR_W       = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      tick,
   input  logic                      enable,
   input  logic [CMD_W-1:0]          x_desired,
   input  logic [CMD_W-1:0]          x_actual,
   input  logic [CMD_W-1:0]          y_desired,
   input  logic [CMD_W-1:0]          y_actual,
   axis_control_scheduler_if.master  ctl,
   output logic [CMD_W-1:0]          x_command,
   output logic [CMD_W-1:0]          y_command,
   output logic                      cmd_valid,
   output logic                      busy,
   output logic                      fault,
   output logic [OVR_W-1:0]          overrun_count
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   sched_state_t     state;
   logic [WD_W-1:0]  wdog;
   logic             done_x;
   logic             done_y;
   logic [CMD_W-1:0] res_x;
   logic [CMD_W-1:0] res_y;
   logic [CMD_W-1:0] op_xd;
   logic [CMD_W-1:0] op_xa;
   logic [CMD_W-1:0] op_yd;
   logic [CMD_W-1:0] op_ya;
   logic             start_q;
   logic [CMD_W-1:0] x_shaped;
   logic [CMD_W-1:0] y_shaped;
   logic             done_x_n;
   logic             done_y_n;
   logic             wd_expired;

   assign ctl.ctl_x_desired = op_xd;
   assign ctl.ctl_x_actual  = op_xa;
   assign ctl.ctl_y_desired = op_yd;
   assign ctl.ctl_y_actual  = op_ya;
   assign ctl.ctl_start     = start_q;

   assign done_x_n   = done_x | ctl.ctl_x_val;
   assign done_y_n   = done_y | ctl.ctl_y_val;
   assign wd_expired = (wdog == WD_LAST);

   cmd_shaper #(
      .CMD_MIN  (CMD_MIN),
      .CMD_MAX  (CMD_MAX),
      .MAX_STEP (MAX_STEP)
   ) u_shape_x (
      .cmd    (res_x),
      .prev   (x_command),
      .shaped (x_shaped)
   );

   cmd_shaper #(
      .CMD_MIN  (CMD_MIN),
      .CMD_MAX  (CMD_MAX),
      .MAX_STEP (MAX_STEP)
   ) u_shape_y (
      .cmd    (res_y),
      .prev   (y_command),
      .shaped (y_shaped)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         wdog          <= '0;
         done_x        <= 1'b0;
         done_y        <= 1'b0;
         res_x         <= '0;
         res_y         <= '0;
         op_xd         <= '0;
         op_xa         <= '0;
         op_yd         <= '0;
         op_ya         <= '0;
         start_q       <= 1'b0;
         x_command     <= CMD_CENTER;
         y_command     <= CMD_CENTER;
         cmd_valid     <= 1'b0;
         busy          <= 1'b0;
         fault         <= 1'b0;
         overrun_count <= '0;
      end else begin
         start_q   <= 1'b0;
         cmd_valid <= 1'b0;

         // Only IDLE accepts a tick; anything else (including PUBLISH and FAULT) drops it.
         if (tick && state != S_IDLE && overrun_count != {OVR_W{1'b1}})
            overrun_count <= overrun_count + OVR_W'(1);

         if (!enable) begin
            state     <= S_IDLE;
            x_command <= CMD_CENTER;
            y_command <= CMD_CENTER;
            busy      <= 1'b0;
            fault     <= 1'b0;
            done_x    <= 1'b0;
            done_y    <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (tick && !fault) begin
                     op_xd   <= x_desired;
                     op_xa   <= x_actual;
                     op_yd   <= y_desired;
                     op_ya   <= y_actual;
                     start_q <= 1'b1;
                     busy    <= 1'b1;
                     state   <= S_LATCH;
                  end
               end
               S_LATCH: begin
                  wdog   <= '0;
                  done_x <= 1'b0;
                  done_y <= 1'b0;
                  state  <= S_ARM;
               end
               S_ARM: begin
                  // A val still high from the previous tick must drop before results count.
                  if (!ctl.ctl_x_val && !ctl.ctl_y_val)
                     state <= S_WAIT;
                  if (wd_expired) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     wdog <= wdog + WD_W'(1);
                  end
               end
               S_WAIT: begin
                  if (ctl.ctl_x_val && !done_x) begin
                     done_x <= 1'b1;
                     res_x  <= ctl.ctl_x_cmd;
                  end
                  if (ctl.ctl_y_val && !done_y) begin
                     done_y <= 1'b1;
                     res_y  <= ctl.ctl_y_cmd;
                  end
                  if (done_x_n && done_y_n) begin
                     state <= S_PUBLISH;
                  end else if (wd_expired) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     wdog <= wdog + WD_W'(1);
                  end
               end
               S_PUBLISH: begin
                  x_command <= x_shaped;
                  y_command <= y_shaped;
                  cmd_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
               S_FAULT: begin
                  state <= S_FAULT;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
